// File: rtl/mc_control_pkg.sv
// Shared types and encodings for the multi-cycle MIPS main control unit.
// Imported by mc_control and mc_imm_decode.
package mc_control_pkg;

  typedef enum logic [3:0] {
    S_FETCH,
    S_DECODE,
    S_MEMADR,
    S_MEMRD,
    S_MEMWB,
    S_MEMWR,
    S_EXEC_R,
    S_RWB,
    S_BRANCH,
    S_JUMP,
    S_EXEC_I,
    S_IWB
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_SLTIU = 6'b001011;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_XORI  = 6'b001110;
  localparam logic [5:0] OP_LUI   = 6'b001111;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_FUNCT = 4'b0010;
  localparam logic [3:0] ALU_BEQ   = 4'b0100;
  localparam logic [3:0] ALU_BNE   = 4'b0101;
  localparam logic [3:0] ALU_ADDI  = 4'b1000;
  localparam logic [3:0] ALU_SLTI  = 4'b1010;
  localparam logic [3:0] ALU_SLTIU = 4'b1011;
  localparam logic [3:0] ALU_ANDI  = 4'b1100;
  localparam logic [3:0] ALU_ORI   = 4'b1101;
  localparam logic [3:0] ALU_XORI  = 4'b1110;
  localparam logic [3:0] ALU_LUI   = 4'b1111;

  localparam logic [1:0] SRCB_RT      = 2'd0;
  localparam logic [1:0] SRCB_FOUR    = 2'd1;
  localparam logic [1:0] SRCB_IMM     = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'd3;

  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // Both 0010xx and 0011xx immediate-ALU opcodes share this prefix.
  function automatic logic is_itype(input logic [5:0] op);
    return op[5:3] == 3'b001;
  endfunction

endpackage

// File: rtl/mc_imm_decode.sv
// Maps the latched opcode to the ALU operation and immediate extension
// mode used by the EXEC_I and BRANCH states.
module mc_imm_decode #(
  parameter int ALUOP_W = 4
) (
  input  logic [5:0]         op,
  output logic [ALUOP_W-1:0] alu_op,
  output logic               zero_ext
);
  import mc_control_pkg::*;

  logic [3:0] code;

  always_comb begin
    code     = ALU_ADD;
    zero_ext = 1'b0;
    case (op)
      OP_BEQ:            code = ALU_BEQ;
      OP_BNE:            code = ALU_BNE;
      OP_ADDI, OP_ADDIU: code = ALU_ADDI;
      OP_SLTI:           code = ALU_SLTI;
      OP_SLTIU:          code = ALU_SLTIU;
      OP_ANDI: begin
        code     = ALU_ANDI;
        zero_ext = 1'b1;
      end
      OP_ORI: begin
        code     = ALU_ORI;
        zero_ext = 1'b1;
      end
      OP_XORI: begin
        code     = ALU_XORI;
        zero_ext = 1'b1;
      end
      OP_LUI:            code = ALU_LUI;
      default:           code = ALU_ADD;
    endcase
  end

  assign alu_op = ALUOP_W'(code);

endmodule

// File: rtl/mc_control.sv
// Multi-cycle MIPS main control FSM: sequences fetch/decode/execute/memory/
// write-back and stalls on the mem_ready handshake.
module mc_control #(
  parameter int ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         opcode,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               MemToReg,
  output logic               RegDst,
  output logic               RegWrite,
  output logic               Link,
  output logic               ZeroExt,
  output logic               BranchNe,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [1:0]         PCSource,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               instr_done,
  output logic               illegal
);
  import mc_control_pkg::*;

  state_t             state;
  state_t             decode_next;
  logic               decode_legal;
  logic [5:0]         op_q;
  logic [ALUOP_W-1:0] imm_alu_op;
  logic               imm_zero_ext;

  mc_imm_decode #(.ALUOP_W(ALUOP_W)) u_imm_decode (
    .op       (op_q),
    .alu_op   (imm_alu_op),
    .zero_ext (imm_zero_ext)
  );

  // DECODE dispatches on the live opcode; op_q is only valid afterwards.
  always_comb begin
    decode_next  = S_FETCH;
    decode_legal = 1'b1;
    if (opcode == OP_LW || opcode == OP_SW)
      decode_next = S_MEMADR;
    else if (opcode == OP_RTYPE)
      decode_next = S_EXEC_R;
    else if (opcode == OP_BEQ || opcode == OP_BNE)
      decode_next = S_BRANCH;
    else if (opcode == OP_J || opcode == OP_JAL)
      decode_next = S_JUMP;
    else if (is_itype(opcode))
      decode_next = S_EXEC_I;
    else
      decode_legal = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_FETCH;
      op_q  <= '0;
    end else begin
      case (state)
        S_FETCH:  if (mem_ready) state <= S_DECODE;
        S_DECODE: begin
          op_q  <= opcode;
          state <= decode_next;
        end
        S_MEMADR: state <= (op_q == OP_LW) ? S_MEMRD : S_MEMWR;
        S_MEMRD:  if (mem_ready) state <= S_MEMWB;
        S_MEMWB:  state <= S_FETCH;
        S_MEMWR:  if (mem_ready) state <= S_FETCH;
        S_EXEC_R: state <= S_RWB;
        S_RWB:    state <= S_FETCH;
        S_BRANCH: state <= S_FETCH;
        S_JUMP:   state <= S_FETCH;
        S_EXEC_I: state <= S_IWB;
        S_IWB:    state <= S_FETCH;
        default:  state <= S_FETCH;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemToReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    Link        = 1'b0;
    ZeroExt     = 1'b0;
    BranchNe    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = SRCB_RT;
    PCSource    = PCSRC_ALU;
    ALUOp       = ALUOP_W'(ALU_ADD);
    instr_done  = 1'b0;
    illegal     = 1'b0;
    case (state)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = SRCB_FOUR;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      S_DECODE: begin
        ALUSrcB = SRCB_IMM_SH2;
        if (!decode_legal) begin
          illegal    = 1'b1;
          instr_done = 1'b1;
        end
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
      end
      S_MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
      end
      S_MEMWB: begin
        RegWrite   = 1'b1;
        MemToReg   = 1'b1;
        instr_done = 1'b1;
      end
      S_MEMWR: begin
        MemWrite   = 1'b1;
        IorD       = 1'b1;
        instr_done = mem_ready;
      end
      S_EXEC_R: begin
        ALUSrcA = 1'b1;
        ALUOp   = ALUOP_W'(ALU_FUNCT);
      end
      S_RWB: begin
        RegWrite   = 1'b1;
        RegDst     = 1'b1;
        instr_done = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        PCWriteCond = 1'b1;
        PCSource    = PCSRC_ALUOUT;
        ALUOp       = imm_alu_op;
        BranchNe    = (op_q == OP_BNE);
        instr_done  = 1'b1;
      end
      S_JUMP: begin
        PCWrite    = 1'b1;
        PCSource   = PCSRC_JUMP;
        RegWrite   = (op_q == OP_JAL);
        Link       = (op_q == OP_JAL);
        instr_done = 1'b1;
      end
      S_EXEC_I: begin
        ALUSrcA = 1'b1;
        ALUSrcB = SRCB_IMM;
        ALUOp   = imm_alu_op;
        ZeroExt = imm_zero_ext;
      end
      S_IWB: begin
        RegWrite   = 1'b1;
        instr_done = 1'b1;
      end
      default: ;
    endcase
    // Kill every state-changing strobe while reset is held, even mid-access.
    if (rst) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed table, hand-written stall and
// reset sequences, and random instructions against a per-cycle trace model.
module tb_mc_control;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          mem_ready;
  logic [5:0]    opcode;
  logic          PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic          MemToReg, RegDst, RegWrite, Link, ZeroExt, BranchNe, ALUSrcA;
  logic [1:0]    ALUSrcB, PCSource;
  logic [AW-1:0] ALUOp;
  logic          instr_done, illegal;

  always #5 clk = ~clk;

  mc_control #(.ALUOP_W(AW)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .MemToReg(MemToReg), .RegDst(RegDst), .RegWrite(RegWrite), .Link(Link),
    .ZeroExt(ZeroExt), .BranchNe(BranchNe), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUOp(ALUOp),
    .instr_done(instr_done), .illegal(illegal)
  );

  typedef struct packed {
    logic          pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write;
    logic          mem_to_reg, reg_dst, reg_write, link, zero_ext, branch_ne;
    logic          alu_src_a;
    logic [1:0]    alu_src_b, pc_source;
    logic [AW-1:0] alu_op;
    logic          instr_done, illegal;
  } ctl_t;

  typedef struct {
    logic mr;
    ctl_t exp;
  } step_t;

  typedef struct {
    logic [5:0] op;
    int         cycles;
    logic       is_illegal;
  } vec_t;

  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011;

  step_t      trace[$];
  int         tests = 0;
  int         fails = 0;
  logic [5:0] legal_ops[14] = '{6'b000000, 6'b000010, 6'b000011, 6'b000100,
                                6'b000101, 6'b001000, 6'b001010, 6'b001011,
                                6'b001100, 6'b001101, 6'b001110, 6'b001111,
                                LW, SW};

  function automatic ctl_t actual();
    ctl_t c;
    c.pc_write = PCWrite;     c.pc_write_cond = PCWriteCond; c.iord = IorD;
    c.mem_read = MemRead;     c.mem_write = MemWrite;        c.ir_write = IRWrite;
    c.mem_to_reg = MemToReg;  c.reg_dst = RegDst;            c.reg_write = RegWrite;
    c.link = Link;            c.zero_ext = ZeroExt;          c.branch_ne = BranchNe;
    c.alu_src_a = ALUSrcA;    c.alu_src_b = ALUSrcB;         c.pc_source = PCSource;
    c.alu_op = ALUOp;         c.instr_done = instr_done;     c.illegal = illegal;
    return c;
  endfunction

  function automatic logic is_legal(input logic [5:0] op);
    foreach (legal_ops[i]) if (legal_ops[i] == op) return 1'b1;
    return op == 6'b001001;
  endfunction

  // ALU codes of the immediate-ALU instructions.
  function automatic logic [AW-1:0] itype_code(input logic [5:0] op);
    case (op)
      6'b001010: return AW'(4'b1010);
      6'b001011: return AW'(4'b1011);
      6'b001100: return AW'(4'b1100);
      6'b001101: return AW'(4'b1101);
      6'b001110: return AW'(4'b1110);
      6'b001111: return AW'(4'b1111);
      default:   return AW'(4'b1000);
    endcase
  endfunction

  function automatic void push(input logic mr, input ctl_t c);
    step_t s;
    s.mr  = mr;
    s.exp = c;
    trace.push_back(s);
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic ctl_t reset_ctl();
    ctl_t c = '0;
    c.alu_src_b = 2'd1;
    return c;
  endfunction

  // Expected per-cycle outputs for one instruction with f fetch stalls and
  // m memory stalls; cycles where mem_ready is ignored get a random value.
  function automatic void buildTrace(input logic [5:0] op, input int f, input int m);
    ctl_t c;
    trace.delete();
    for (int i = 0; i <= f; i++) begin
      c = '0; c.mem_read = 1; c.alu_src_b = 2'd1;
      c.pc_write = (i == f); c.ir_write = (i == f);
      push(i == f, c);
    end
    c = '0; c.alu_src_b = 2'd3;
    if (!is_legal(op)) begin
      c.illegal = 1; c.instr_done = 1;
      push(rbit(), c);
      return;
    end
    push(rbit(), c);
    if (op == LW || op == SW) begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 2'd2;
      push(rbit(), c);
      for (int i = 0; i <= m; i++) begin
        c = '0; c.iord = 1;
        if (op == LW) c.mem_read = 1;
        else begin c.mem_write = 1; c.instr_done = (i == m); end
        push(i == m, c);
      end
      if (op == LW) begin
        c = '0; c.reg_write = 1; c.mem_to_reg = 1; c.instr_done = 1;
        push(rbit(), c);
      end
    end else if (op == 6'b000000) begin
      c = '0; c.alu_src_a = 1; c.alu_op = AW'(4'b0010);
      push(rbit(), c);
      c = '0; c.reg_write = 1; c.reg_dst = 1; c.instr_done = 1;
      push(rbit(), c);
    end else if (op == 6'b000100 || op == 6'b000101) begin
      c = '0; c.alu_src_a = 1; c.pc_write_cond = 1; c.pc_source = 2'd1;
      c.instr_done = 1; c.branch_ne = op[0];
      c.alu_op = op[0] ? AW'(4'b0101) : AW'(4'b0100);
      push(rbit(), c);
    end else if (op == 6'b000010 || op == 6'b000011) begin
      c = '0; c.pc_write = 1; c.pc_source = 2'd2; c.instr_done = 1;
      c.reg_write = op[0]; c.link = op[0];
      push(rbit(), c);
    end else begin
      c = '0; c.alu_src_a = 1; c.alu_src_b = 2'd2; c.alu_op = itype_code(op);
      c.zero_ext = (op == 6'b001100 || op == 6'b001101 || op == 6'b001110);
      push(rbit(), c);
      c = '0; c.reg_write = 1; c.instr_done = 1;
      push(rbit(), c);
    end
  endfunction

  task automatic checkOutput(input string name, input ctl_t exp);
    ctl_t act = actual();
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic checkValue(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Called just after a rising edge with the DUT in FETCH.
  task automatic applyStimulus(input logic [5:0] op);
    opcode = op;
    foreach (trace[i]) begin
      mem_ready = trace[i].mr;
      @(negedge clk);
      checkOutput($sformatf("op=%b cycle%0d", op, i + 1), trace[i].exp);
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[$];

  initial begin
    int         cycles, wr_cycles, done_cycle;
    logic       done, saw_illegal;
    logic [5:0] op;

    vecs = '{'{LW, 5, 1'b0}, '{SW, 4, 1'b0}, '{6'b000000, 4, 1'b0},
             '{6'b001000, 4, 1'b0}, '{6'b001111, 4, 1'b0}, '{6'b000100, 3, 1'b0},
             '{6'b000101, 3, 1'b0}, '{6'b000010, 3, 1'b0}, '{6'b000011, 3, 1'b0},
             '{6'b111111, 2, 1'b1}, '{6'b000001, 2, 1'b1}, '{6'b010000, 2, 1'b1}};

    rst = 1'b1; mem_ready = 1'b1; opcode = '0;
    @(negedge clk);
    checkOutput("reset_gated", reset_ctl());
    mem_ready = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    foreach (vecs[v]) begin
      opcode = vecs[v].op; mem_ready = 1'b1;
      cycles = 0; done = 1'b0; saw_illegal = 1'b0;
      while (!done && cycles < 20) begin
        @(negedge clk);
        cycles++;
        if (illegal) saw_illegal = 1'b1;
        done = instr_done;
        @(posedge clk); #1;
      end
      checkValue($sformatf("cycles op=%b", vecs[v].op), cycles, vecs[v].cycles);
      checkValue($sformatf("illegal op=%b", vecs[v].op), int'(saw_illegal),
                 int'(vecs[v].is_illegal));
    end

    foreach (legal_ops[i]) begin
      buildTrace(legal_ops[i], 0, 0);
      applyStimulus(legal_ops[i]);
    end
    buildTrace(6'b111111, 0, 0);
    applyStimulus(6'b111111);

    // sw with three stalled MEMWR cycles.
    opcode = SW; wr_cycles = 0; done_cycle = 0;
    for (int c = 1; c <= 7; c++) begin
      mem_ready = (c <= 3 || c == 7);
      @(negedge clk);
      if (MemWrite) wr_cycles++;
      if (instr_done) done_cycle = c;
      @(posedge clk); #1;
    end
    mem_ready = 1'b0;
    @(negedge clk);
    checkValue("sw_stall_memwrite_cycles", wr_cycles, 4);
    checkValue("sw_stall_done_cycle", done_cycle, 7);
    checkValue("sw_stall_memwrite_after", int'(MemWrite), 0);
    checkValue("sw_stall_back_in_fetch", int'(MemRead), 1);
    @(posedge clk); #1;

    // Reset asserted in the middle of a stalled MEMRD.
    opcode = LW; mem_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    mem_ready = 1'b0;
    @(negedge clk);
    checkValue("memrd_before_reset", int'(MemRead), 1);
    #1 rst = 1'b1;
    #1 checkOutput("memrd_reset_same_cycle", reset_ctl());
    @(posedge clk); #1;
    rst = 1'b0;
    #1 begin
      ctl_t f = reset_ctl();
      f.mem_read = 1'b1;
      checkOutput("fetch_after_reset", f);
    end
    @(posedge clk); #1;
    buildTrace(LW, 1, 1);
    applyStimulus(LW);

    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 9) < 7) op = legal_ops[$urandom_range(0, 13)];
      else begin
        op = 6'($urandom);
        while (op == 6'b001001) op = 6'($urandom);
      end
      buildTrace(op, $urandom_range(0, 2), $urandom_range(0, 2));
      applyStimulus(op);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
